epb_master: RTL and testbench
=============================

EPB_MASTER -- requirements
Module: epb_master

Interface
REQ-001 Parameter ADDR_W, default 24, EPB address width.
REQ-002 Parameter DATA_W, default 32, EPB data width; fixed at 32, with 4 byte enables.
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum strobe cycles to wait for ready.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 epb_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 epb_rst_n  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  command present.
REQ-008 cmd_ready  out  1  command accepted on the cycle where valid and ready are both high.
REQ-009 cmd_wr  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_W  target address.
REQ-011 cmd_be  in  4  byte enables, active-high.
REQ-012 cmd_wdata  in  32  write data.
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_rdata  out  32  read data; valid with rsp_valid.
REQ-015 rsp_timeout  out  1  transaction timed out; valid with rsp_valid.
REQ-016 epb_cs_n_o  out  1  chip select, active-low.
REQ-017 epb_r_w_n_o  out  1  1 = read, 0 = write.
REQ-018 epb_be_n_o  out  4  byte enables, active-low.
REQ-019 epb_addr_o  out  ADDR_W  bus address.
REQ-020 epb_data_out_o  out  32  write data toward the tristate buffer.
REQ-021 epb_data_oe_n_o  out  1  buffer output enable, active-low.
REQ-022 epb_data_in_i  in  32  read data from the buffer.
REQ-023 epb_rdy_i  in  1  responder ready, active-high, synchronous to epb_clk.

Function
REQ-024 The FSM states SHALL be IDLE, SETUP, STROBE, HOLD and RESP.
REQ-025 cmd_ready SHALL be 1 only in IDLE; an accepted command SHALL be registered and the FSM SHALL move to SETUP.
REQ-026 SETUP, 1 cycle, SHALL drive:
- epb_addr_o, epb_r_w_n_o = ~cmd_wr and epb_be_n_o = ~cmd_be;
- for a write: epb_data_out_o and epb_data_oe_n_o = 0;
- epb_cs_n_o = 1.
REQ-027 STROBE SHALL drive epb_cs_n_o = 0 and sample epb_rdy_i every cycle; on rdy = 1 it SHALL capture epb_data_in_i into rsp_rdata (reads only) and go to HOLD.
REQ-028 HOLD, 1 cycle, SHALL drive epb_cs_n_o = 1 while addr, be, r_w_n and write data stay stable.
REQ-029 RESP, 1 cycle, SHALL pulse rsp_valid, drive epb_data_oe_n_o = 1 and return to IDLE.
REQ-030 Latency: accept at cycle N with rdy at the first STROBE cycle (N+2) SHALL give rsp_valid at N+4; back-to-back commands SHALL have a minimum period of 5 cycles.
REQ-031 On a write completion, rsp_rdata SHALL be 0.
REQ-032 epb_data_oe_n_o SHALL be 0 only from SETUP through HOLD of a write; it SHALL be 1 throughout reads.
REQ-033 Bus address, byte enable and r_w_n outputs SHALL hold their last values in IDLE.
REQ-034 Commands presented outside IDLE SHALL be ignored (cmd_ready = 0) and SHALL NOT be lost by a held-valid producer.

Reset
REQ-035 Asserting epb_rst_n = 0, including mid-transaction, SHALL immediately force:
- epb_cs_n_o = 1, epb_r_w_n_o = 1, epb_be_n_o = 4'hF, epb_data_oe_n_o = 1;
- epb_addr_o = 0, epb_data_out_o = 0, rsp_rdata = 0;
- rsp_valid = 0, rsp_timeout = 0, cmd_ready = 0, state = IDLE.
REQ-036 An aborted transaction SHALL produce no response; cmd_ready SHALL rise on the first clock edge after reset release.

Configuration
REQ-037 With macro EPB_MASTER_TIMEOUT_EN defined:
- a counter SHALL count STROBE cycles;
- when it reaches TIMEOUT_CYC without rdy, the FSM SHALL go to HOLD with rsp_timeout = 1 and rsp_rdata = 32'hDEAD_DEAD;
- rdy in the same cycle as the terminal count SHALL win, giving a normal completion.
REQ-038 Without EPB_MASTER_TIMEOUT_EN, STROBE SHALL wait indefinitely, rsp_timeout SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-039 Package epb_master_pkg SHALL hold the state enum, EPB_BE_W = 4, EPB_DATA_W = 32 and the timeout fill constant 32'hDEAD_DEAD.
REQ-040 Sub-module epb_timeout_ctr SHALL implement the clear/enable/terminal-count counter and SHALL be instantiated only under EPB_MASTER_TIMEOUT_EN.

Verification
REQ-041 Write 0x12345678 to address 0x000040, be 4'hF, rdy at first STROBE: cs_n low for exactly 1 cycle, oe_n low for 3 cycles, rsp_valid at N+4 with rsp_timeout = 0.
REQ-042 Read address 0x000100, responder drives 0xCAFEF00D with rdy after 3 STROBE cycles: rsp_rdata = 0xCAFEF00D, oe_n stays 1, cs_n low for 3 cycles.
REQ-043 Back-to-back writes with cmd_valid held high: second accept exactly 5 cycles after the first, with no command dropped.
REQ-044 With TIMEOUT_EN and TIMEOUT_CYC = 8, rdy never asserted: rsp_timeout = 1 and rsp_rdata = 0xDEADDEAD; rdy at STROBE cycle 8 gives a normal response.
REQ-045 Reset asserted during STROBE of a write: all bus outputs at reset values asynchronously, no rsp_valid, cmd_ready = 1 one cycle after release.
REQ-046 Byte-enable write with be = 4'b0101: epb_be_n_o = 4'b1010 held from SETUP through HOLD.

Source files
------------

// File: rtl/epb_master_pkg.sv
// Shared state encoding, widths and constants for the EPB bus master.
package epb_master_pkg;

  localparam int unsigned EPB_BE_W   = 4;
  localparam int unsigned EPB_DATA_W = 32;

  // Read data returned when a strobe times out
  localparam logic [EPB_DATA_W-1:0] EPB_TIMEOUT_FILL = 32'hDEAD_DEAD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } epb_state_e;

  typedef struct packed {
    logic                  timeout;
    logic [EPB_DATA_W-1:0] rdata;
  } epb_rsp_t;

endpackage

// File: rtl/epb_timeout_ctr.sv
// Strobe-length counter with clear/enable and a terminal-count flag.
// Only built when EPB_MASTER_TIMEOUT_EN is defined.
`ifdef EPB_MASTER_TIMEOUT_EN
module epb_timeout_ctr
  import epb_master_pkg::*;
#(
  parameter int unsigned CNT_MAX = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_c_o
);

  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter holds the number of completed enabled cycles since the last clear
  assign tc_c_o = (cnt_q == CNT_W'(CNT_MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_c_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/epb_master.sv
// EPB bus master: converts valid/ready commands into SETUP/STROBE/HOLD bus cycles.
// Define EPB_MASTER_TIMEOUT_EN to bound the strobe phase at TIMEOUT_CYC cycles.
module epb_master
  import epb_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                epb_clk,
  input  logic                epb_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [EPB_BE_W-1:0] cmd_be,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_timeout,
  output logic                epb_cs_n_o,
  output logic                epb_r_w_n_o,
  output logic [EPB_BE_W-1:0] epb_be_n_o,
  output logic [ADDR_W-1:0]   epb_addr_o,
  output logic [DATA_W-1:0]   epb_data_out_o,
  output logic                epb_data_oe_n_o,
  input  logic [DATA_W-1:0]   epb_data_in_i,
  input  logic                epb_rdy_i
);

  epb_state_e          state_q,     state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                cs_n_q,      cs_n_d;
  logic                r_w_n_q,     r_w_n_d;
  logic [EPB_BE_W-1:0] be_n_q,      be_n_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   dout_q,      dout_d;
  logic                oe_n_q,      oe_n_d;
  logic                rsp_valid_q, rsp_valid_d;
  epb_rsp_t            rsp_q,       rsp_d;
  logic                timeout_c;

`ifdef EPB_MASTER_TIMEOUT_EN
  logic tc_c;

  epb_timeout_ctr #(
    .CNT_MAX (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk_i   (epb_clk),
    .rst_ni  (epb_rst_n),
    .clear_i (state_q != ST_STROBE),
    .en_i    (state_q == ST_STROBE),
    .tc_c_o  (tc_c)
  );

  assign timeout_c = tc_c;
`else
  logic unused_timeout_cyc;

  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_c          = 1'b0;
`endif

  // Next-state and registered-output logic; bus fields hold unless updated
  always_comb begin
    state_d     = state_q;
    cs_n_d      = cs_n_q;
    r_w_n_d     = r_w_n_q;
    be_n_d      = be_n_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    oe_n_d      = oe_n_q;
    rsp_d       = rsp_q;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d = ST_SETUP;
          addr_d  = cmd_addr;
          r_w_n_d = ~cmd_wr;
          be_n_d  = ~cmd_be;
          if (cmd_wr) begin
            dout_d = cmd_wdata;
            oe_n_d = 1'b0;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cs_n_d  = 1'b0;
      end
      ST_STROBE: begin
        // Ready in the terminal-count cycle still completes normally
        if (epb_rdy_i || timeout_c) begin
          state_d       = ST_HOLD;
          cs_n_d        = 1'b1;
          rsp_d.timeout = ~epb_rdy_i;
          if (!epb_rdy_i) begin
            rsp_d.rdata = EPB_TIMEOUT_FILL;
          end else if (r_w_n_q) begin
            rsp_d.rdata = epb_data_in_i;
          end else begin
            rsp_d.rdata = '0;
          end
        end
      end
      ST_HOLD: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        oe_n_d      = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge epb_clk or negedge epb_rst_n) begin
    if (!epb_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      cs_n_q      <= 1'b1;
      r_w_n_q     <= 1'b1;
      be_n_q      <= '1;
      addr_q      <= '0;
      dout_q      <= '0;
      oe_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cs_n_q      <= cs_n_d;
      r_w_n_q     <= r_w_n_d;
      be_n_q      <= be_n_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      oe_n_q      <= oe_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_q.rdata;
  assign rsp_timeout     = rsp_q.timeout;
  assign epb_cs_n_o      = cs_n_q;
  assign epb_r_w_n_o     = r_w_n_q;
  assign epb_be_n_o      = be_n_q;
  assign epb_addr_o      = addr_q;
  assign epb_data_out_o  = dout_q;
  assign epb_data_oe_n_o = oe_n_q;

endmodule

// File: tb/tb_epb_master.sv
// Scoreboard bench for epb_master: random commands, a responder model and a response monitor.
module tb_epb_master;

  localparam int unsigned TO_CYC = 8;
`ifdef EPB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [23:0] cmd_addr;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        epb_cs_n_o;
  logic        epb_r_w_n_o;
  logic [3:0]  epb_be_n_o;
  logic [23:0] epb_addr_o;
  logic [31:0] epb_data_out_o;
  logic        epb_data_oe_n_o;
  logic [31:0] epb_data_in_i;
  logic        epb_rdy_i;

  epb_master #(
    .ADDR_W      (24),
    .DATA_W      (32),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .epb_clk         (clk),
    .epb_rst_n       (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_wr          (cmd_wr),
    .cmd_addr        (cmd_addr),
    .cmd_be          (cmd_be),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_timeout     (rsp_timeout),
    .epb_cs_n_o      (epb_cs_n_o),
    .epb_r_w_n_o     (epb_r_w_n_o),
    .epb_be_n_o      (epb_be_n_o),
    .epb_addr_o      (epb_addr_o),
    .epb_data_out_o  (epb_data_out_o),
    .epb_data_oe_n_o (epb_data_oe_n_o),
    .epb_data_in_i   (epb_data_in_i),
    .epb_rdy_i       (epb_rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned dly;
    int unsigned acc;
  } exp_t;

  typedef struct {
    int unsigned dly;
    logic [31:0] rdata;
  } resp_t;

  exp_t        exp_q[$];
  resp_t       resp_q[$];
  int unsigned cyc     = 0;
  int unsigned n_chk   = 0;
  int unsigned n_fail  = 0;
  int unsigned n_sent  = 0;
  int unsigned n_rsp   = 0;
  int unsigned strobe_n = 0;
  int unsigned cs_lo   = 0;
  int unsigned oe_lo   = 0;
  int unsigned bus_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Responder: ready after dly strobe cycles, garbage on the data bus otherwise
  always @(negedge clk) begin
    epb_data_in_i = $urandom();
    epb_rdy_i     = 1'b0;
    if (rst_n && !epb_cs_n_o && resp_q.size() > 0) begin
      if (strobe_n == resp_q[0].dly) begin
        epb_rdy_i     = 1'b1;
        epb_data_in_i = resp_q[0].rdata;
      end
      strobe_n++;
    end else if (strobe_n != 0) begin
      strobe_n = 0;
      if (resp_q.size() > 0) void'(resp_q.pop_front());
    end
  end

  // Monitor: bus window bookkeeping and response scoreboard
  always @(negedge clk) begin
    exp_t        e;
    bit          to;
    int unsigned ns;
    logic [31:0] exp_rd;
    if (!rst_n) begin
      cs_lo = 0; oe_lo = 0; bus_err = 0;
    end else begin
      if (exp_q.size() > 0 && cyc >= exp_q[0].acc) begin
        if (!epb_cs_n_o) cs_lo++;
        if (!epb_data_oe_n_o) oe_lo++;
        if (epb_addr_o !== exp_q[0].addr || epb_be_n_o !== ~exp_q[0].be ||
            epb_r_w_n_o !== ~exp_q[0].wr || cmd_ready !== 1'b0 ||
            (exp_q[0].wr && epb_data_out_o !== exp_q[0].wdata))
          bus_err++;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e      = exp_q.pop_front();
          to     = TO_EN && (e.dly >= TO_CYC);
          ns     = to ? TO_CYC : e.dly + 1;
          exp_rd = to ? 32'hDEAD_DEAD : (e.wr ? 32'h0 : e.rdata);
          n_rsp++;
          chk("rsp_rdata", rsp_rdata, exp_rd);
          chk("rsp_timeout", rsp_timeout, to);
          chk("rsp_latency", cyc - e.acc, ns + 2);
          chk("cs_low_cycles", cs_lo, ns);
          chk("oe_low_cycles", oe_lo, e.wr ? ns + 2 : 0);
          chk("bus_fields_stable", bus_err, 0);
          cs_lo = 0; oe_lo = 0; bus_err = 0;
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [23:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] rd, input int unsigned dly,
                      input bit track, input bit hold, output int unsigned acc);
    exp_t  e;
    resp_t r;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_be = be; cmd_wdata = wd;
    acc = 0;
    for (int t = 0; t < 400; t++) begin
      if (cmd_ready) begin
        acc = cyc + 1;
        r.dly = dly; r.rdata = rd;
        resp_q.push_back(r);
        if (track) begin
          e.wr = wr; e.addr = addr; e.be = be; e.wdata = wd; e.rdata = rd;
          e.dly = dly; e.acc = acc;
          exp_q.push_back(e);
          n_sent++;
        end
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("accept_wait", cmd_ready, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cs_n"}, epb_cs_n_o, 1);
    chk({tag, "_r_w_n"}, epb_r_w_n_o, 1);
    chk({tag, "_be_n"}, epb_be_n_o, 4'hF);
    chk({tag, "_oe_n"}, epb_data_oe_n_o, 1);
    chk({tag, "_addr"}, epb_addr_o, 0);
    chk({tag, "_dout"}, epb_data_out_o, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
  endtask

  task automatic release_reset(input string tag);
    rst_n = 1'b1;
    #1;
    chk({tag, "_ready_at_release"}, cmd_ready, 0);
    @(negedge clk);
    chk({tag, "_ready_after_edge"}, cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a0, a1, a2;
    logic        wr;
    int unsigned dly;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_be = '0; cmd_wdata = '0;
    epb_rdy_i = 1'b0; epb_data_in_i = '0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    release_reset("por");

    send(1'b1, 24'h000040, 4'hF, 32'h1234_5678, 32'h0, 0, 1'b1, 1'b0, a0);
    repeat (2) @(negedge clk);
    send(1'b0, 24'h000100, 4'hF, 32'h0, 32'hCAFE_F00D, 2, 1'b1, 1'b0, a0);
    send(1'b1, 24'h000200, 4'b0101, 32'hA5A5_5A5A, 32'h0, 1, 1'b1, 1'b0, a0);

    // Back-to-back writes with valid held high
    send(1'b1, 24'h000300, 4'hF, 32'h1111_1111, 32'h0, 0, 1'b1, 1'b1, a0);
    send(1'b1, 24'h000304, 4'hF, 32'h2222_2222, 32'h0, 0, 1'b1, 1'b1, a1);
    send(1'b1, 24'h000308, 4'h3, 32'h3333_3333, 32'h0, 0, 1'b1, 1'b0, a2);
    chk("b2b_period_1", a1 - a0, 5);
    chk("b2b_period_2", a2 - a1, 5);

`ifdef EPB_MASTER_TIMEOUT_EN
    send(1'b0, 24'h000400, 4'hF, 32'h0, 32'h1357_9BDF, 100, 1'b1, 1'b0, a0);
    send(1'b0, 24'h000404, 4'hF, 32'h0, 32'h2468_ACE0, TO_CYC - 1, 1'b1, 1'b0, a0);
`endif

    // Reset during the strobe of a write: no response must appear
    while (exp_q.size() != 0 && cyc < 5000) @(negedge clk);
    send(1'b1, 24'h000500, 4'hF, 32'hBEEF_0001, 32'h0, 100, 1'b0, 1'b0, a0);
    for (int t = 0; t < 20 && epb_cs_n_o; t++) @(negedge clk);
    chk("strobe_reached", epb_cs_n_o, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid");
    repeat (2) @(negedge clk);
    release_reset("mid");

    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom_range(0, 1));
      dly = (TO_EN && $urandom_range(0, 5) == 0) ? 100 : $urandom_range(0, 6);
      send(wr, 24'($urandom()), 4'($urandom()), $urandom(), $urandom(), dly,
           1'b1, 1'($urandom_range(0, 1)), a0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    cmd_valid = 1'b0;

    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    chk("rsp_count", n_rsp, n_sent);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
